// File: rtl/mux21_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux21_arbiter
// Purpose  : Two-requester round-robin arbiter for the shared mux21 datapath.
//            Owns the mux select, grants one requester at a time with a
//            burst limit, and registers the selected word into a one-entry
//            valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module mux21_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAXBURST = 4   // legal range 1..15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  output logic             GNT0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT1,
  output logic             S,
  output logic [WIDTH-1:0] Y,
  output logic             YV,
  input  logic             YRDY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAXBURST);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             yv_q, yv_d;

  logic             free;
  logic             beat;

  // Grants: the current owner is accepted whenever the output stage can take a word
  always_comb begin
    free = ~yv_q | YRDY;
    GNT0 = (state_q == ST_OWN0) & REQ0 & free;
    GNT1 = (state_q == ST_OWN1) & REQ1 & free;
    beat = GNT0 | GNT1;
  end

  // Output stage: load on a beat, otherwise drain when the consumer takes the word.
  // S always tracks the owner while in OWNx, so it doubles as the data select.
  always_comb begin
    y_d  = y_q;
    yv_d = yv_q;
    if (beat) begin
      y_d  = s_q ? D1 : D0;
      yv_d = 1'b1;
    end else if (yv_q & YRDY) begin
      yv_d = 1'b0;
    end
  end

  // Ownership FSM: round-robin on ties, hand over on request drop or burst limit
  always_comb begin
    logic       own_id;
    logic       req_own;
    logic       req_oth;
    logic       nxt;
    logic [3:0] cnt_inc;

    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    s_d     = s_q;
    own_id  = (state_q == ST_OWN1);
    req_own = own_id ? REQ1 : REQ0;
    req_oth = own_id ? REQ0 : REQ1;
    nxt     = 1'b0;
    cnt_inc = cnt_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (REQ0 | REQ1) begin
          // On a tie the requester that did not own last wins
          nxt     = (REQ0 & REQ1) ? ~last_q : REQ1;
          state_d = nxt ? ST_OWN1 : ST_OWN0;
          s_d     = nxt;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!req_own) begin
          // Request drop takes priority over a coincident burst-limit beat
          last_d = own_id;
          cnt_d  = 4'd0;
          if (req_oth) begin
            state_d = own_id ? ST_OWN0 : ST_OWN1;
            s_d     = ~own_id;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (beat) begin
          if (cnt_inc == MAX_CNT) begin
            cnt_d = 4'd0;
            if (req_oth) begin
              last_d  = own_id;
              state_d = own_id ? ST_OWN0 : ST_OWN1;
              s_d     = ~own_id;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output-stage registers; reset discards any held word
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      s_q     <= 1'b0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      s_q     <= s_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign S  = s_q;
  assign Y  = y_q;
  assign YV = yv_q;

endmodule
`default_nettype wire

// File: tb/tb_mux21_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux21_arbiter
// Purpose  : Self-checking bench for mux21_arbiter using a behavioural
//            ownership model plus a word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux21_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAXBURST = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             REQ0, REQ1, YRDY;
  logic [WIDTH-1:0] D0, D1, Y;
  logic             GNT0, GNT1, S, YV;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner is -1 (nobody), 0 or 1
  int               m_own;
  int               m_cnt;
  int               m_last;
  logic             m_s;
  logic [WIDTH-1:0] m_y;
  logic             m_yv;
  logic [WIDTH-1:0] sb[$];

  always #5 CLK = ~CLK;

  mux21_arbiter #(.WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .CLK (CLK),
    .RST (RST),
    .REQ0(REQ0),
    .D0  (D0),
    .GNT0(GNT0),
    .REQ1(REQ1),
    .D1  (D1),
    .GNT1(GNT1),
    .S   (S),
    .Y   (Y),
    .YV  (YV),
    .YRDY(YRDY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_cnt  = 0;
    m_last = 1;
    m_s    = 1'b0;
    m_y    = '0;
    m_yv   = 1'b0;
    sb.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model
  task automatic step(input logic rst, input logic r0, input logic [WIDTH-1:0] d0,
                      input logic r1, input logic [WIDTH-1:0] d1, input logic rdy);
    bit free, g0, g1;
    int x, o;
    bit rq[2];
    @(negedge CLK);
    RST = rst; REQ0 = r0; D0 = d0; REQ1 = r1; D1 = d1; YRDY = rdy;
    #1;
    rq[0] = r0;
    rq[1] = r1;
    free  = !m_yv || rdy;
    g0    = (m_own == 0) && r0 && free;
    g1    = (m_own == 1) && r1 && free;
    chk("GNT0", 32'(GNT0), 32'(g0));
    chk("GNT1", 32'(GNT1), 32'(g1));
    chk("S",    32'(S),    32'(m_s));
    chk("YV",   32'(YV),   32'(m_yv));
    chk("Y",    32'(Y),    32'(m_y));
    if (!rst && m_yv && rdy) begin
      if (sb.size() > 0) chk("SB_WORD", 32'(Y), 32'(sb[0]));
      else               chk("SB_EMPTY", 32'(sb.size()), 32'd1);
    end

    if (rst) begin
      model_reset();
    end else begin
      if (m_yv && rdy && sb.size() > 0) void'(sb.pop_front());
      if (g0 || g1) begin
        m_y  = g0 ? d0 : d1;
        m_yv = 1'b1;
        sb.push_back(m_y);
      end else if (m_yv && rdy) begin
        m_yv = 1'b0;
      end
      if (m_own < 0) begin
        m_cnt = 0;
        if (r0 && r1)  m_own = 1 - m_last;
        else if (r0)   m_own = 0;
        else if (r1)   m_own = 1;
        if (m_own >= 0) m_s = m_own[0];
      end else begin
        x = m_own;
        o = 1 - x;
        if (!rq[x]) begin
          m_last = x;
          m_cnt  = 0;
          m_own  = rq[o] ? o : -1;
          if (m_own == o) m_s = o[0];
        end else if (g0 || g1) begin
          m_cnt++;
          if (m_cnt == MAXBURST) begin
            m_cnt = 0;
            if (rq[o]) begin
              m_last = x;
              m_own  = o;
              m_s    = o[0];
            end
          end
        end
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return WIDTH'($urandom);
  endfunction

  initial begin
    logic [WIDTH-1:0] pat[5];
    pat = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; D0 = '0; D1 = '0; YRDY = 1'b0;
    repeat (2) @(posedge CLK);
    model_reset();

    // Reset then idle
    repeat (5) step(0, 0, rnd(), 0, rnd(), 1);

    // Single requester, streaming, burst limit does not stall without competition
    step(0, 1, 8'h00, 0, rnd(), 1);
    for (int i = 0; i < 5; i++) step(0, 1, pat[i], 0, rnd(), 1);
    repeat (3) step(0, 1, rnd(), 0, rnd(), 1);
    repeat (2) step(0, 0, rnd(), 0, rnd(), 1);

    // Round-robin with both requesting
    repeat (20) step(0, 1, rnd(), 1, rnd(), 1);
    repeat (2) step(0, 0, rnd(), 0, rnd(), 1);

    // Backpressure
    step(0, 1, 8'h01, 0, rnd(), 1);
    step(0, 1, 8'h01, 0, rnd(), 1);
    repeat (4) step(0, 1, rnd(), 0, rnd(), 0);
    repeat (3) step(0, 1, rnd(), 0, rnd(), 1);
    repeat (2) step(0, 0, rnd(), 0, rnd(), 1);

    // Requester drop while owning 1 after two beats
    for (int i = 0; i < 30 && !(m_own == 1 && m_cnt == 2); i++)
      step(0, 1, rnd(), 1, rnd(), 1);
    step(0, 1, rnd(), 0, rnd(), 1);
    repeat (2) step(0, 1, rnd(), 0, rnd(), 1);
    repeat (3) step(0, 0, rnd(), 0, rnd(), 1);

    // Reset mid-burst, then requester 0 must win the tie
    for (int i = 0; i < 30 && !(m_own == 1 && m_cnt == 2); i++)
      step(0, 1, rnd(), 1, rnd(), 1);
    step(1, 1, rnd(), 1, rnd(), 1);
    repeat (6) step(0, 1, rnd(), 1, rnd(), 1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rnd(),
           ($urandom_range(0, 3) != 0), rnd(), ($urandom_range(0, 2) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
